// File: rtl/alu_nibble_sequencer_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: FSM states,
// slice width, and the common 4-bit function-select codes.
package alu_nibble_sequencer_pkg;

    // Width of one ALU slice operand/result.
    localparam int NIB_W = 4;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Select codes for the common operations (active-high data convention).
    // S_ADD: M=0, A plus B (+1 when cn_n=0).
    // S_SUB: M=0 with cn_n=0 gives A minus B; with cn_n=1 gives A minus B minus 1.
    // S_XOR: M=1, A xor B.
    localparam logic [3:0] S_ADD = 4'b1001;
    localparam logic [3:0] S_SUB = 4'b0110;
    localparam logic [3:0] S_XOR = 4'b0110;

endpackage

// File: rtl/alu_nibble_sequencer.sv
// Drives one external 4-bit ALU slice across an NIBBLES-nibble operand,
// LSB nibble first. Carry is registered between nibbles, so there is no
// combinational path from slice_cn4_n back to slice_cn_n.
module alu_nibble_sequencer
    import alu_nibble_sequencer_pkg::*;
#(
    parameter int NIBBLES = 4,
    localparam int W      = NIB_W * NIBBLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cn_n,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     result,
    output logic             cn4_n,
    output logic             a_eq_b,
    output logic             zero,
    output logic [NIB_W-1:0] slice_a,
    output logic [NIB_W-1:0] slice_b,
    output logic [3:0]       slice_s,
    output logic             slice_m,
    output logic             slice_cn_n,
    input  logic [NIB_W-1:0] slice_f,
    input  logic             slice_cn4_n,
    input  logic             slice_aeb
);

    localparam int              IW   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0]   LAST = IW'(NIBBLES - 1);

    seq_state_e                      state_q;
    logic [NIBBLES-1:0][NIB_W-1:0]   a_q, b_q, result_q, result_d;
    logic [3:0]                      s_q;
    logic                            m_q;
    logic                            carry_q;
    logic                            aeb_q;
    logic                            busy_q;
    logic                            done_q;
    logic [IW-1:0]                   idx_q;

    // Splice the slice output into the current nibble of the result word.
    always_comb begin
        result_d         = result_q;
        result_d[idx_q]  = slice_f;
    end

    // Sequencer FSM: latch on start, one nibble per RUN cycle, one-cycle DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            m_q      <= 1'b0;
            carry_q  <= 1'b1;
            aeb_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        s_q      <= s;
                        m_q      <= m;
                        carry_q  <= cn_n;
                        idx_q    <= '0;
                        result_q <= '0;
                        aeb_q    <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    result_q <= result_d;
                    carry_q  <= slice_cn4_n;
                    aeb_q    <= aeb_q & slice_aeb;
                    if (idx_q == LAST) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                ST_DONE: begin
                    // Starts seen here are dropped; next accept is back in IDLE.
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Slice drive straight from the latched registers.
    assign slice_a    = a_q[idx_q];
    assign slice_b    = b_q[idx_q];
    assign slice_s    = s_q;
    assign slice_m    = m_q;
    assign slice_cn_n = carry_q;

    // Result side; carry register doubles as the top-nibble carry-out.
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cn4_n  = carry_q;
    assign a_eq_b = aeb_q;
    assign zero   = (result_q == '0);

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer: behavioural 4-bit slice model on the
// slice_* ports, whole-word reference model, directed and random operations.
module tb_alu_nibble_sequencer;
    import alu_nibble_sequencer_pkg::*;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic [3:0]   s;
    logic         m, cn_n;
    logic         busy, done, cn4_n, a_eq_b, zero;
    logic [W-1:0] result;
    logic [3:0]   slice_a, slice_b, slice_s, slice_f;
    logic         slice_m, slice_cn_n, slice_cn4_n, slice_aeb;

    int n_checks = 0;
    int n_errors = 0;

    alu_nibble_sequencer #(.NIBBLES(NIB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .s(s), .m(m),
        .cn_n(cn_n), .busy(busy), .done(done), .result(result), .cn4_n(cn4_n),
        .a_eq_b(a_eq_b), .zero(zero), .slice_a(slice_a), .slice_b(slice_b),
        .slice_s(slice_s), .slice_m(slice_m), .slice_cn_n(slice_cn_n),
        .slice_f(slice_f), .slice_cn4_n(slice_cn4_n), .slice_aeb(slice_aeb)
    );

    always #5 clk = ~clk;

    // Behavioural slice: gate-level X/Y terms, F = X+Y+cin or ~(X^Y).
    always_comb begin
        logic [3:0] x, y;
        logic [4:0] sum;
        x = slice_a | (slice_b & {4{slice_s[0]}}) | (~slice_b & {4{slice_s[1]}});
        y = (slice_a & ~slice_b & {4{slice_s[2]}}) | (slice_a & slice_b & {4{slice_s[3]}});
        sum = {1'b0, x} + {1'b0, y} + {4'b0, ~slice_cn_n};
        slice_f     = slice_m ? ~(x ^ y) : sum[3:0];
        slice_cn4_n = ~sum[4];
        slice_aeb   = (slice_f == 4'hF);
    end

    // Whole-word reference: function table of the slice applied to W bits.
    function automatic void ref_op(input logic [W-1:0] ai, bi, input logic [3:0] si,
                                   input logic mi, ci, output logic [W-1:0] r,
                                   output logic co_n, output logic eq);
        logic [W-1:0] x, y, ones;
        logic [W:0]   sum;
        ones = '1;
        case (si)
            4'd0:  begin x = ai;        y = '0;        end
            4'd1:  begin x = ai | bi;   y = '0;        end
            4'd2:  begin x = ai | ~bi;  y = '0;        end
            4'd3:  begin x = ones;      y = '0;        end
            4'd4:  begin x = ai;        y = ai & ~bi;  end
            4'd5:  begin x = ai | bi;   y = ai & ~bi;  end
            4'd6:  begin x = ai;        y = ~bi;       end
            4'd7:  begin x = ai & ~bi;  y = ones;      end
            4'd8:  begin x = ai;        y = ai & bi;   end
            4'd9:  begin x = ai;        y = bi;        end
            4'd10: begin x = ai | ~bi;  y = ai & bi;   end
            4'd11: begin x = ai & bi;   y = ones;      end
            4'd12: begin x = ai;        y = ai;        end
            4'd13: begin x = ai | bi;   y = ai;        end
            4'd14: begin x = ai | ~bi;  y = ai;        end
            default: begin x = ai;      y = ones;      end
        endcase
        sum  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ~ci};
        co_n = ~sum[W];
        if (!mi) r = sum[W-1:0];
        else begin
            case (si)
                4'd0:  r = ~ai;
                4'd1:  r = ~(ai | bi);
                4'd2:  r = ~ai & bi;
                4'd3:  r = '0;
                4'd4:  r = ~(ai & bi);
                4'd5:  r = ~bi;
                4'd6:  r = ai ^ bi;
                4'd7:  r = ai & ~bi;
                4'd8:  r = ~ai | bi;
                4'd9:  r = ~(ai ^ bi);
                4'd10: r = bi;
                4'd11: r = ai & bi;
                4'd12: r = ones;
                4'd13: r = ai | ~bi;
                4'd14: r = ai | bi;
                default: r = ai;
            endcase
        end
        eq = (r == ones);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch one operation from IDLE (#1 after an edge), check it, and
    // leave the DUT back in IDLE at the earliest next-start slot.
    task automatic run_op(input string tag, input logic [W-1:0] ai, bi,
                          input logic [3:0] si, input logic mi, ci);
        int n;
        logic [W-1:0] er;
        logic eco, eeq;
        a = ai; b = bi; s = si; m = mi; cn_n = ci; start = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            start = 1'b0;
        end while (!done && n < 20);
        ref_op(ai, bi, si, mi, ci, er, eco, eeq);
        chk({tag, " latency"}, n, 5);
        chk({tag, " result"}, result, er);
        chk({tag, " cn4_n"}, cn4_n, eco);
        chk({tag, " a_eq_b"}, a_eq_b, eeq);
        chk({tag, " zero"}, zero, (er == '0));
        chk({tag, " busy_in_done"}, busy, 1);
        @(posedge clk); #1;
        chk({tag, " done_pulse"}, done, 0);
        chk({tag, " busy_idle"}, busy, 0);
        chk({tag, " hold"}, result, er);
    endtask

    initial begin
        int dones;
        rst_n = 1'b0; start = 1'b0;
        a = '0; b = '0; s = '0; m = 1'b0; cn_n = 1'b1;
        #12;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst result", result, 0);
        chk("rst cn4_n", cn4_n, 1);
        chk("rst a_eq_b", a_eq_b, 0);
        chk("rst zero", zero, 1);
        chk("rst slice_cn_n", slice_cn_n, 1);
        chk("rst slice_a", slice_a, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        run_op("add", 16'h1234, 16'h4321, S_ADD, 1'b0, 1'b1);
        chk("add value", result, 16'h5555);
        run_op("ovf", 16'hFFFF, 16'h0001, S_ADD, 1'b0, 1'b1);
        chk("ovf cout", cn4_n, 0);
        run_op("sub", 16'h5000, 16'h1000, S_SUB, 1'b0, 1'b0);
        chk("sub value", result, 16'h4000);
        run_op("cmp", 16'hABCD, 16'hABCD, S_SUB, 1'b0, 1'b1);
        chk("cmp eq", a_eq_b, 1);
        run_op("xor0", 16'hF0F0, 16'hFF00, S_XOR, 1'b1, 1'b0);
        chk("xor0 value", result, 16'h0FF0);
        run_op("xor1", 16'hF0F0, 16'hFF00, S_XOR, 1'b1, 1'b1);
        chk("xor1 value", result, 16'h0FF0);

        // Start held through the whole op including the DONE cycle:
        // exactly one operation, one done pulse.
        a = 16'h0102; b = 16'h0304; s = S_ADD; m = 1'b0; cn_n = 1'b1;
        start = 1'b1; dones = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (i == 5) start = 1'b0;
            if (done) dones++;
        end
        chk("hold dones", dones, 1);
        chk("hold result", result, 16'h0406);
        // Back-to-back: second start in the cycle right after done.
        run_op("b2b1", 16'h0F0F, 16'h0101, S_ADD, 1'b0, 1'b0);
        run_op("b2b2", 16'h7777, 16'h1111, S_SUB, 1'b0, 1'b0);

        // Reset asserted mid-operation at k=2.
        a = 16'h1111; b = 16'h2222; s = S_ADD; m = 1'b0; cn_n = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst busy", busy, 0);
        chk("mid rst done", done, 0);
        chk("mid rst result", result, 0);
        chk("mid rst cn4_n", cn4_n, 1);
        chk("mid rst a_eq_b", a_eq_b, 0);
        chk("mid rst zero", zero, 1);
        chk("mid rst slice_b", slice_b, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst", 16'h1234, 16'h4321, S_ADD, 1'b0, 1'b1);

        // Random operations over every select, mode and carry-in.
        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = (i % 7 == 0) ? ra : W'($urandom);
            run_op("rand", ra, rb, 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
